mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single byte-wide 64 KiB program/data memory between three requesters: external loader (port 0), CPU instruction fetch (port 1), CPU data access (port 2).
- Splits each 16-bit access into two sequential byte cycles, little-endian: low byte at addr, high byte at addr+1.
- Sits between the CPU core, the memory macro and the program loader. It replaces direct memory indexing in the core.

Parameters:
- AW, 16, memory address width; byte address wraps modulo 2^AW.
- NREQ, 3, number of requesters. Fixed at 3; the arbitration policy below is defined only for 3.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- req  in  3  per-port request; bit i belongs to port i
- we  in  3  per-port write enable (1 = write)
- wide  in  3  per-port size (1 = 16-bit, 0 = 8-bit)
- addr  in  3*AW  per-port byte address; port i occupies bits [i*AW +: AW]
- wdata  in  48  per-port write data; port i occupies bits [i*16 +: 16]
- loader_lock  in  1  while high, ports 1 and 2 are never granted
- ack  out  3  one-cycle completion pulse per port
- rdata  out  16  read data, valid in the ack cycle of a read
- busy  out  1  high in any state other than IDLE
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory byte write strobe
- mem_addr  out  AW  memory byte address
- mem_wdata  out  8  memory write byte
- mem_rdata  in  8  memory read byte; synchronous, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = "last served = port 2", so port 1 wins the first tie.
- Reset mid-transaction aborts at once: no ack is issued, and a partial wide write may leave only the low byte written.
- States: IDLE, B0, B1, CAP, ACK.
- IDLE: sample req.
  - Port 0 has absolute priority.
  - Otherwise, if loader_lock = 0, ports 1 and 2 round-robin: if both request, grant the one not last served.
  - On grant: latch port id, we, wide, addr and wdata; go to B0.
  - No request: stay in IDLE.
- B0: mem_en = 1, mem_addr = latched addr, mem_we = we, mem_wdata = wdata[7:0].
  - Next state: B1 if wide; else CAP if read; else ACK.
- B1: mem_en = 1, mem_addr = addr + 1 (AW-bit wrap, so FFFF to 0000), mem_we = we, mem_wdata = wdata[15:8].
  - On a read, capture mem_rdata as the low byte.
  - Next state: CAP if read, else ACK.
- CAP: mem_en = 0; capture mem_rdata as the last byte. A wide read stores it as the high byte; a narrow read stores it as the low byte with the high byte 0. Next state ACK.
- ACK:
  - ack[granted] = 1 for exactly this cycle.
  - rdata = the assembled word on reads. On writes rdata holds its previous value.
  - Update the round-robin pointer if the granted port was 1 or 2.
  - Next state IDLE.
- mem_en, mem_we, mem_addr and mem_wdata are registered and change only on state entry. Outside B0/B1, mem_en = mem_we = 0.
- Latency from IDLE cycle with req high to ack cycle:
  - narrow write 2 cycles
  - narrow read 3 cycles
  - wide write 3 cycles
  - wide read 4 cycles
- Handshake:
  - A requester holds req until it sees ack, then deasserts req on that same edge.
  - A req high in IDLE is always a new request.
  - Operand or req changes after grant are ignored.
- Requests arriving while busy wait. No request is lost or reordered per port.
- loader_lock rising during a CPU transaction does not abort it; it only blocks subsequent grants.
- Starvation bound: with port 0 idle and lock low, a pending port 1 or port 2 request is granted within 2 transactions.
- At most one ack bit is high in any cycle.

Test Plan:
- Port 1 narrow read of 0x0010 (mem 0x0010 = 0xA5) -> busy rises; ack[1] exactly 3 cycles after the req sample; rdata = 0x00A5.
- Port 2 wide write of 0xBEEF to 0xFFFF -> mem 0xFFFF = 0xEF and 0x0000 = 0xBE (wraps); ack[2] 3 cycles after the sample; wide read back gives rdata = 0xBEEF.
- Ports 1 and 2 requesting continuously -> grants alternate 1, 2, 1, 2 starting with port 1 after reset; no two acks in one cycle.
- Ports 0, 1 and 2 all requesting -> port 0 served first; then 1, then 2. With loader_lock = 1 and ports 1/2 requesting -> no ack[1] or ack[2] for 20 cycles.
- rst pulsed during B1 of a wide write -> all outputs 0 immediately, no ack, state IDLE; the next request completes with normal latency.
- Narrow write of 0x1234 to 0x0020 -> mem 0x0020 = 0x34, mem 0x0021 unchanged; ack after 2 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide memory between the loader,
// CPU fetch and CPU data ports; 16-bit accesses become two byte cycles.
module mem_port_arbiter #(
    parameter int AW   = 16,
    parameter int NREQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ-1:0]    wide,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*16-1:0] wdata,
    input  logic               loader_lock,
    output logic [NREQ-1:0]    ack,
    output logic [15:0]        rdata,
    output logic               busy,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [7:0]         mem_wdata,
    input  logic [7:0]         mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        B0,
        B1,
        CAP,
        ACK
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [1:0]      r_id;
    logic            r_we;
    logic            r_wide;
    logic [AW-1:0]   r_addr;
    logic [15:0]     r_wdata;
    logic [7:0]      r_lo;
    logic            r_last2;

    logic            w_gnt;
    logic [1:0]      w_id;
    logic            w_we;
    logic            w_wide;
    logic [AW-1:0]   w_addr;
    logic [15:0]     w_wdata;

    assign busy = (r_state != IDLE);

    // Grant selection: loader first, then fair alternation between CPU ports
    always_comb begin
        w_gnt = 1'b0;
        w_id  = 2'd0;
        if (req[0]) begin
            w_gnt = 1'b1;
            w_id  = 2'd0;
        end else if (!loader_lock) begin
            if (req[1] && (!req[2] || r_last2)) begin
                w_gnt = 1'b1;
                w_id  = 2'd1;
            end else if (req[2]) begin
                w_gnt = 1'b1;
                w_id  = 2'd2;
            end
        end
    end

    // Operand mux for the port about to be granted
    always_comb begin
        w_we    = we[0];
        w_wide  = wide[0];
        w_addr  = addr[0 +: AW];
        w_wdata = wdata[0 +: 16];
        case (w_id)
            2'd1: begin
                w_we    = we[1];
                w_wide  = wide[1];
                w_addr  = addr[AW +: AW];
                w_wdata = wdata[16 +: 16];
            end
            2'd2: begin
                w_we    = we[2];
                w_wide  = wide[2];
                w_addr  = addr[2*AW +: AW];
                w_wdata = wdata[32 +: 16];
            end
            default: ;
        endcase
    end

    // Next-state logic: byte cycles, optional capture cycle, then ack
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_gnt) w_next = B0;
            B0: begin
                if (r_wide)    w_next = B1;
                else if (r_we) w_next = ACK;
                else           w_next = CAP;
            end
            B1:      w_next = r_we ? ACK : CAP;
            CAP:     w_next = ACK;
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Operand latch, read assembly, ack pulse and registered memory strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id      <= 2'd0;
            r_we      <= 1'b0;
            r_wide    <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_lo      <= '0;
            r_last2   <= 1'b1;
            ack       <= '0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (r_state == IDLE && w_gnt) begin
                r_id    <= w_id;
                r_we    <= w_we;
                r_wide  <= w_wide;
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
            end
            if (r_state == B1 && !r_we)
                r_lo <= mem_rdata;
            if (r_state == CAP)
                rdata <= r_wide ? {mem_rdata, r_lo} : {8'h00, mem_rdata};
            ack <= (w_next == ACK) ? (NREQ'(1) << r_id) : '0;
            if (r_state == ACK && r_id != 2'd0)
                r_last2 <= (r_id == 2'd2);
            if (r_state == IDLE && w_gnt) begin
                mem_en    <= 1'b1;
                mem_we    <= w_we;
                mem_addr  <= w_addr;
                mem_wdata <= w_wdata[7:0];
            end else if (r_state == B0 && r_wide) begin
                mem_en    <= 1'b1;
                mem_we    <= r_we;
                mem_addr  <= r_addr + AW'(1);
                mem_wdata <= r_wdata[15:8];
            end else begin
                mem_en    <= 1'b0;
                mem_we    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed traffic on three ports, checked
// by a transaction-level reference model through an expected-ack queue.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  we = '0;
    logic [2:0]  wide = '0;
    logic [47:0] addr = '0;
    logic [47:0] wdata = '0;
    logic        loader_lock = 1'b0;
    logic [2:0]  ack;
    logic [15:0] rdata;
    logic        busy;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    mem_port_arbiter #(.AW(16), .NREQ(3)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .wide(wide),
        .addr(addr), .wdata(wdata), .loader_lock(loader_lock),
        .ack(ack), .rdata(rdata), .busy(busy), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous byte memory seen by the DUT
    logic [7:0] ram [65536];
    initial begin
        forever begin
            @(posedge clk);
            if (mem_en) begin
                if (mem_we) ram[mem_addr] = mem_wdata;
                else        mem_rdata <= ram[mem_addr];
            end
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: transaction-level memory and arbitration rules
    typedef struct {
        int          port;
        int          cyc;
        logic [15:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          ack_log[$];
    logic [7:0]  ref_mem [65536];
    int          m_free = 0;
    int          m_last = 2;
    logic [15:0] m_rdata = '0;
    logic [2:0]  just_acked = '0;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 8));
    endfunction

    task automatic model_step();
        int p;
        int lat;
        logic [15:0] a;
        logic [15:0] a1;
        logic [15:0] d;
        exp_t e;
        if (cyc < m_free) return;
        p = -1;
        if (req[0]) p = 0;
        else if (!loader_lock) begin
            if (req[1] && req[2]) p = (m_last == 1) ? 2 : 1;
            else if (req[1])      p = 1;
            else if (req[2])      p = 2;
        end
        if (p < 0) return;
        a   = addr[p*16 +: 16];
        a1  = a + 16'd1;
        d   = wdata[p*16 +: 16];
        lat = 2 + (wide[p] ? 1 : 0) + (we[p] ? 0 : 1);
        if (we[p]) begin
            ref_mem[a] = d[7:0];
            if (wide[p]) ref_mem[a1] = d[15:8];
        end else begin
            m_rdata = wide[p] ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
        end
        e.port  = p;
        e.cyc   = cyc + lat;
        e.rdata = m_rdata;
        exp_q.push_back(e);
        if (p != 0) m_last = p;
        m_free = cyc + lat + 1;
    endtask

    // Monitor: every ack is matched against the oldest expected transaction
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (ack != 3'b000) begin
                chk("ack_onehot", $countones(ack), 1);
                ack_log.push_back(ack[0] ? 0 : (ack[1] ? 1 : 2));
                if (exp_q.size() == 0) begin
                    chk("ack_unexpected", ack, 3'b000);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_port", ack, 3'b001 << e.port);
                    chk("ack_cycle", cyc, e.cyc);
                    chk("ack_rdata", rdata, e.rdata);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                chk("ack_missing", ack, 3'b001 << e.port);
            end
        end
    end

    task automatic tick();
        model_step();
        @(negedge clk);
        just_acked = ack & req;
        req = req & ~ack;
    endtask

    task automatic issue(input int p, input bit w, input bit wd,
                         input logic [15:0] a, input logic [15:0] d);
        we[p]             = w;
        wide[p]           = wd;
        addr[p*16 +: 16]  = a;
        wdata[p*16 +: 16] = d;
        req[p]            = 1'b1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        loader_lock = 1'b0;
        while ((exp_q.size() != 0 || req != 3'b000) && k < 400) begin
            tick();
            k++;
        end
        chk("drain_req", req, 3'b000);
        chk("drain_queue", exp_q.size(), 0);
    endtask

    // Called at a falling edge; leaves rst low at the next falling edge
    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        loader_lock = 1'b0;
        #1;
        chk("rst_ack", ack, 3'b000);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_free = cyc;
        m_last = 2;
        m_rdata = '0;
        just_acked = '0;
    endtask

    function automatic logic [15:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            2:       return 16'($urandom_range(16'h0040, 16'h004F));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] old;
        int bad;
        int first;
        for (int i = 0; i < 65536; i++) begin
            ram[i]     = init_byte(i);
            ref_mem[i] = init_byte(i);
        end
        @(negedge clk);
        do_reset();

        ram[16'h0010] = 8'hA5; ref_mem[16'h0010] = 8'hA5;
        issue(1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        tick();
        chk("t1_busy", busy, 1'b1);
        chk("t1_mem_en", mem_en, 1'b1);
        chk("t1_mem_addr", mem_addr, 16'h0010);
        drain();
        chk("t1_rdata", rdata, 16'h00A5);

        issue(2, 1'b1, 1'b1, 16'hFFFF, 16'hBEEF);
        drain();
        chk("t2_ram_ffff", ram[16'hFFFF], 8'hEF);
        chk("t2_ram_0000", ram[16'h0000], 8'hBE);
        issue(2, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
        drain();
        chk("t2_rdata", rdata, 16'hBEEF);

        ram[16'h0021] = 8'h5A; ref_mem[16'h0021] = 8'h5A;
        issue(1, 1'b1, 1'b0, 16'h0020, 16'h1234);
        drain();
        chk("t8_ram_0020", ram[16'h0020], 8'h34);
        chk("t8_ram_0021", ram[16'h0021], 8'h5A);

        old = ref_mem[16'h0301];
        issue(2, 1'b1, 1'b1, 16'h0300, 16'hC3D4);
        tick();
        tick();
        chk("rm_busy", busy, 1'b1);
        chk("rm_mem_en", mem_en, 1'b1);
        chk("rm_mem_we", mem_we, 1'b1);
        chk("rm_mem_addr", mem_addr, 16'h0301);
        chk("rm_mem_wdata", mem_wdata, 8'hC3);
        do_reset();
        ref_mem[16'h0301] = old;
        chk("rm_ram_lo", ram[16'h0300], 8'hD4);
        chk("rm_ram_hi", ram[16'h0301], old);
        issue(1, 1'b0, 1'b1, 16'h0300, 16'h0000);
        drain();

        do_reset();
        ack_log.delete();
        for (int n = 0; n < 40; n++) begin
            for (int p = 1; p < 3; p++)
                if (!req[p] && !just_acked[p])
                    issue(p, 1'($urandom), 1'($urandom), rand_addr(), 16'($urandom));
            tick();
        end
        drain();
        chk("rr_0", ack_log[0], 1);
        chk("rr_1", ack_log[1], 2);
        chk("rr_2", ack_log[2], 1);
        chk("rr_3", ack_log[3], 2);

        do_reset();
        ack_log.delete();
        issue(0, 1'b0, 1'b1, 16'h0040, 16'h0000);
        issue(1, 1'b1, 1'b0, 16'h0041, 16'h0077);
        issue(2, 1'b0, 1'b0, 16'h0041, 16'h0000);
        drain();
        chk("prio_0", ack_log[0], 0);
        chk("prio_1", ack_log[1], 1);
        chk("prio_2", ack_log[2], 2);

        ack_log.delete();
        loader_lock = 1'b1;
        issue(1, 1'b0, 1'b0, 16'h0042, 16'h0000);
        issue(2, 1'b1, 1'b1, 16'h0044, 16'h9988);
        repeat (20) tick();
        chk("lock_acks", ack_log.size(), 0);
        drain();

        repeat (1500) begin
            for (int p = 0; p < 3; p++)
                if (!req[p] && !just_acked[p] &&
                    $urandom_range(0, (p == 0) ? 15 : 3) == 0)
                    issue(p, 1'($urandom), 1'($urandom), rand_addr(), 16'($urandom));
            if ($urandom_range(0, 15) == 0) loader_lock = ~loader_lock;
            tick();
        end
        drain();

        bad = 0;
        first = 0;
        for (int i = 0; i < 65536; i++)
            if (ram[i] !== ref_mem[i]) begin
                if (bad == 0) first = i;
                bad++;
            end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL mem_image: %0d bytes differ, first %04h got %02h expected %02h",
                     bad, first, ram[first], ref_mem[first]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
